// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, constants and frame helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } rx_state_t;

    localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;

    // Bits on the wire for one frame: start + data + optional parity + stop.
    function automatic int frame_length(input int data_width, input int parity_enabled);
        return data_width + parity_enabled + 2;
    endfunction

endpackage

// File: rtl/uart_synchronizer.sv
// rtl/uart_synchronizer.sv - N-flop synchronizer for an asynchronous input, resets high
module uart_synchronizer #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; idle-high line resets to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - mid-bit sampling UART receiver; UART_RX_FRAMING_CHECK_EN enables stop-bit checking
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        framing_error,
    output logic                        rx_busy
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = $clog2(INPUT_DATA_WIDTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(INPUT_DATA_WIDTH - 1);
    localparam logic          ODD       = (PARITY_TYPE != 0);

    rx_state_t state, state_next;

    logic                        serial_in_synced;
    logic                        serial_prev;
    logic                        start_detected;
    logic [CW-1:0]               clk_cnt;
    logic [BW-1:0]               bit_cnt;
    logic [INPUT_DATA_WIDTH-1:0] shift_reg;
    logic                        parity_mismatch;
    logic                        stop_low;

    logic clr_cnt;
    logic shift_en;
    logic bit_inc;
    logic parity_en;
    logic stop_en;

    uart_synchronizer #(
        .STAGES (NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (serial_in),
        .sync_out (serial_in_synced)
    );

    // Previous synchronized value, used to find the falling edge of a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            serial_prev <= 1'b1;
        end else begin
            serial_prev <= serial_in_synced;
        end
    end

    // Only a 1->0 transition starts a frame, so a held-low line cannot retrigger.
    assign start_detected = serial_prev & ~serial_in_synced;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-sample strobes for the datapath.
    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        parity_en  = 1'b0;
        stop_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start_detected) begin
                    state_next = START_BIT;
                    clr_cnt    = 1'b1;
                end
            end
            START_BIT: begin
                if (clk_cnt == HALF_LAST) begin
                    clr_cnt    = 1'b1;
                    state_next = serial_in_synced ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (clk_cnt == BIT_LAST) begin
                    clr_cnt  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_next = (PARITY_ENABLED != 0) ? PARITY_BIT : STOP_BIT;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY_BIT: begin
                if (clk_cnt == BIT_LAST) begin
                    clr_cnt    = 1'b1;
                    parity_en  = 1'b1;
                    state_next = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (clk_cnt == BIT_LAST) begin
                    clr_cnt    = 1'b1;
                    stop_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clock-per-bit counter runs only while a frame is in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
        end else if (clr_cnt || state == IDLE) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    // Data bit index; restarts on every start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else if (state == START_BIT || (shift_en && !bit_inc)) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // LSB-first reception: each sample enters at the MSB and moves down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {serial_in_synced, shift_reg[INPUT_DATA_WIDTH-1:1]};
        end
    end

    // Parity mismatch is latched at the parity sample and cleared for each new frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_mismatch <= 1'b0;
        end else if (state == START_BIT) begin
            parity_mismatch <= 1'b0;
        end else if (parity_en) begin
            parity_mismatch <= (^shift_reg) ^ serial_in_synced ^ ODD;
        end
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    assign stop_low = ~serial_in_synced;

    // Framing pulse when the stop bit is low and parity was fine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            framing_error <= 1'b0;
        end else begin
            framing_error <= stop_en & ~parity_mismatch & stop_low;
        end
    end
`else
    assign stop_low      = 1'b0;
    assign framing_error = 1'b0;
`endif

    // Registered result pulses; parity errors take precedence over framing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
            if (stop_en) begin
                if (parity_mismatch) begin
                    rx_error <= 1'b1;
                end else if (!stop_low) begin
                    received_data <= shift_reg;
                    data_is_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled at default parameters
module tb_uart_rx_oversampled;

    localparam int CPB     = 8;
    localparam int LATENCY = 88;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] received_data;
    logic       data_is_valid;
    logic       rx_error;
    logic       framing_error;
    logic       rx_busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       sb[$];
    logic [7:0] last_good;

    uart_rx_oversampled dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_is_valid (data_is_valid),
        .rx_error      (rx_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (data_is_valid || rx_error || framing_error) begin
            if (sb.size() == 0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_pulse observed v=%0b e=%0b f=%0b expected none at cycle %0d",
                           data_is_valid, rx_error, framing_error, cyc);
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", 32'({framing_error, rx_error, data_is_valid}), 32'(e.kind));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("received_data", 32'(received_data), 32'(e.data));
            end
        end
    end

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.data = (kind == K_VALID) ? d : last_good;
        e.cyc  = cyc + LATENCY;
        sb.push_back(e);
        if (kind == K_VALID) last_good = d;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        int n;
        exp_t e;
        logic [7:0] d55;

        reset     = 1'b0;
        serial_in = 1'b1;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_received_data", 32'(received_data), 32'h0);
        chk("reset_valid", 32'(data_is_valid), 32'h0);
        chk("reset_rx_error", 32'(rx_error), 32'h0);
        chk("reset_framing", 32'(framing_error), 32'h0);
        chk("reset_busy", 32'(rx_busy), 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good byte with correct even parity.
        send_frame(8'hA5, even_par(8'hA5), 1'b1, K_VALID);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Wrong parity: error pulse, data held at 0xA5.
        send_frame(8'h3C, ~even_par(8'h3C), 1'b1, K_PERR);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Two-cycle glitch is rejected at the start-bit sample.
        n = cyc;
        serial_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        serial_in = 1'b1;
        wait_to(n + 4);
        chk("glitch_busy_enter", 32'(rx_busy), 32'h1);
        wait_to(n + 7);
        chk("glitch_busy_hold", 32'(rx_busy), 32'h1);
        wait_to(n + 8);
        chk("glitch_busy_drop", 32'(rx_busy), 32'h0);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Break: 30 bit periods low. All-zero data has even parity, so only the stop bit is bad.
`ifdef UART_RX_FRAMING_CHECK_EN
        e.kind = K_FERR;
        e.data = last_good;
`else
        e.kind = K_VALID;
        e.data = 8'h00;
        last_good = 8'h00;
`endif
        e.cyc = cyc + LATENCY;
        sb.push_back(e);
        serial_in = 1'b0;
        repeat (30 * CPB) @(posedge clk);
        #1;
        chk("break_no_retrigger", 32'(rx_busy), 32'h0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h5A, even_par(8'h5A), 1'b1, K_VALID);
        drive_bit(1'b1);

        // Back-to-back frames, no idle gap.
        send_frame(8'h01, even_par(8'h01), 1'b1, K_VALID);
        send_frame(8'hFF, even_par(8'hFF), 1'b1, K_VALID);
        send_frame(8'h80, even_par(8'h80), 1'b1, K_VALID);
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk("pending_before_reset", 32'(sb.size()), 32'h0);

        // Reset in the middle of data bit 4 of 0x55.
        d55 = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d55[i]);
        serial_in = d55[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(rx_busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("midreset_received_data", 32'(received_data), 32'h0);
        chk("midreset_valid", 32'(data_is_valid), 32'h0);
        chk("midreset_busy", 32'(rx_busy), 32'h0);
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        last_good = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        send_frame(8'h55, even_par(8'h55), 1'b1, K_VALID);
        drive_bit(1'b1);
        drive_bit(1'b1);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        chk("final_busy", 32'(rx_busy), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Standalone UART receiver that recovers frames from the asynchronous `serial_in` line by counting `CLOCKS_PER_BIT` system clocks per bit and sampling at mid-bit. Serves as the receive end of the team's UART link: it accepts frames from the existing transmitter (1 start bit, LSB-first data, optional parity bit, 1 stop bit) or from an off-chip device. It delivers each byte as a one-cycle valid pulse and flags parity and framing errors.

## Interface
- `INPUT_DATA_WIDTH`, 8, data bits per frame (≥ 5).
- `PARITY_ENABLED`, 1, 1 = parity bit present between data and stop bit; 0 = no parity bit.
- `PARITY_TYPE`, 0, 0 = even parity, 1 = odd parity. Ignored when `PARITY_ENABLED` = 0.
- `CLOCKS_PER_BIT`, 8, `clk` cycles per bit period. Must be even and ≥ 4.
- `clk`  input  1  single system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `serial_in`  input  1  asynchronous serial line; idles high.
- `received_data`  output  `INPUT_DATA_WIDTH`  last good byte; held until the next good frame.
- `data_is_valid`  output  1  one-cycle pulse when `received_data` updates.
- `rx_error`  output  1  one-cycle pulse on a parity mismatch.
- `framing_error`  output  1  one-cycle pulse when the stop bit is sampled low (see Configuration).
- `rx_busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: three flops on `serial_in`, each resetting to 1. The third stage is `serial_in_synced`. A previous-value flop (reset 1) gives `start_detected` = previous & !current.
- FSM states: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- Bit counter: 0..`INPUT_DATA_WIDTH`-1. Clock counter: 0..`CLOCKS_PER_BIT`-1.
- IDLE:
  - On `start_detected`, go to START_BIT and clear the clock counter.
  - A line held low never re-triggers; a new frame requires a 1→0 transition.
- START_BIT:
  - At count `CLOCKS_PER_BIT`/2-1, sample the line.
  - Sample 1: false start, return to IDLE with no outputs.
  - Sample 0: go to DATA_BITS and clear the counter.
- DATA_BITS:
  - Every `CLOCKS_PER_BIT` cycles, shift the sampled bit into the MSB of the shift register (LSB-first reception).
  - After bit `INPUT_DATA_WIDTH`-1, go to PARITY_BIT if `PARITY_ENABLED`, else to STOP_BIT.
- PARITY_BIT:
  - Latch the mismatch flag = (^data) ^ parity_sample ^ `PARITY_TYPE`.
- STOP_BIT, at the sample point:
  - Mismatch set: pulse `rx_error`. `data_is_valid` stays low and `received_data` is unchanged.
  - Stop bit sampled 0 (with the macro defined): pulse `framing_error`; no valid pulse.
  - Otherwise: load `received_data` and pulse `data_is_valid`.
  - In every case, return to IDLE on the same edge.
- Reset values: `received_data` = 0; `data_is_valid`, `rx_error`, `framing_error`, `rx_busy` = 0; FSM = IDLE; counters = 0; synchronizer = 1.
- Reset asserted mid-frame discards the frame immediately; no pulses.

## Timing
- Sample points (clk cycles after entering START_BIT): `CLOCKS_PER_BIT`/2-1 + k·`CLOCKS_PER_BIT`.
  - k = 0: start bit. k = 1..W: data bits. k = W+1: parity bit. k = W+1+P: stop bit.
- Latency, serial_in low → `data_is_valid` pulse: 4 + `CLOCKS_PER_BIT`/2 + (W+1+P)·`CLOCKS_PER_BIT` cycles. At defaults this is 88 cycles.
- Output pulses last exactly one cycle and are registered.
- Back-to-back frames with zero idle between stop and next start are received without loss.

## Configuration
- `UART_RX_FRAMING_CHECK_EN`:
  - Defined: a low stop sample pulses `framing_error` and suppresses `data_is_valid`.
  - Undefined: the stop sample is ignored, the frame is accepted on parity alone, and `framing_error` is tied 0.

## Structure
- Package `uart_pkg` holds:
  - the FSM state encoding;
  - `NUMBER_OF_RX_SYNCHRONIZERS` = 3;
  - a function computing frame length (`INPUT_DATA_WIDTH` + `PARITY_ENABLED` + 2).
- Sub-module `uart_synchronizer`: parameterized N-flop synchronizer with async active-low reset, reset value 1. Reused by other CDC inputs.

## Test plan
- Byte 0xA5, even parity bit 0, valid stop bit → `data_is_valid` pulses 88 cycles after the start edge; `received_data` = 0xA5; `rx_error` = 0.
- Byte 0x3C sent with wrong parity bit 1 → `rx_error` pulses once; no valid pulse; `received_data` keeps its previous value.
- Low glitch of 2 cycles on an idle line → returns to IDLE at the start-bit sample; no pulses; `rx_busy` drops after 4 cycles in START_BIT.
- Line held low for 30 bit periods (break), with `UART_RX_FRAMING_CHECK_EN` defined:
  - exactly one `framing_error` pulse and no `data_is_valid`;
  - after the line returns high, byte 0x5A is received correctly.
- Back-to-back bytes 0x01, 0xFF, 0x80 with no idle gap → three valid pulses spaced 11·`CLOCKS_PER_BIT` = 88 cycles apart, with the correct data each time.
- `reset` driven low during data bit 4 of 0x55 → outputs go to 0 immediately; a frame 0x55 sent after reset release is received correctly.
